otp_ecc_reg_reader: RTL and testbench
=====================================

OTP_ECC_REG_READER -- requirements
Module: otp_ecc_reg_reader

Interface
REQ-001 SHALL have parameter Depth, default 1: number of 64-bit words to read (integer, >= 1); top level sets it from the partition info struct member (part_info_t.x).
REQ-002 SHALL have localparam Aw, = max(1, $clog2(Depth)): address width.
REQ-003 clk_i  input  1  single clock; all logic rising-edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  start a full sweep; sampled only in IDLE.
REQ-006 rd_req_o  output  1  read request to the ECC register storage.
REQ-007 rd_addr_o  output  Aw  word address of the current request.
REQ-008 rd_gnt_i  input  1  storage accepts the request this cycle.
REQ-009 rd_valid_i  input  1  rd_data_i/rd_ecc_i valid; 1..N cycles after the grant.
REQ-010 rd_data_i  input  64  data word.
REQ-011 rd_ecc_i  input  8  check bits; bit k = even parity of data byte k.
REQ-012 busy_o  output  1  sweep in progress.
REQ-013 done_o  output  1  one-cycle pulse at sweep end.
REQ-014 err_o  output  1  sticky: at least one word failed the check this sweep.
REQ-015 err_addr_o  output  Aw  address of the first failing word.
REQ-016 digest_o  output  64  XOR of all data words read this sweep.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, CHECK, DONE.
REQ-018 IDLE->REQ on start_i=1: clears err_o, err_addr_o, digest_o; address counter set to 0.
REQ-019 REQ: rd_req_o=1 and held with stable rd_addr_o until rd_gnt_i=1; then ->WAIT.
REQ-020 WAIT: rd_req_o=0; on rd_valid_i=1, capture data/ecc and ->CHECK; a rd_valid_i outside WAIT SHALL be ignored.
REQ-021 CHECK (one cycle): digest_o ^= data; syndrome[k] = ^data[8k+7:8k] ^ ecc[k]; nonzero syndrome with err_o=0 -> err_o=1, err_addr_o=address; later failures leave err_addr_o unchanged.
REQ-022 CHECK: address == Depth-1 -> DONE; otherwise address+1 -> REQ; the address SHALL NOT wrap past Depth-1.
REQ-023 DONE: done_o=1 for exactly one cycle, then ->IDLE; err_o/err_addr_o/digest_o hold until the next start.
REQ-024 busy_o=1 in REQ, WAIT, CHECK, DONE; 0 in IDLE.
REQ-025 start_i while busy SHALL be ignored; start_i in the IDLE cycle right after DONE SHALL begin a new sweep.
REQ-026 Minimum per-word latency (gnt in the REQ cycle, valid the cycle after) SHALL be 3 cycles, so a Depth-word sweep takes >= 3*Depth+1 cycles from start to done_o.
REQ-027 Depth=1: a single read is issued at address 0, then DONE.

Reset
REQ-028 rst_i=1 at a clock edge SHALL force IDLE and zero every output and internal register, including mid-sweep.
REQ-029 After a mid-sweep reset, no done_o pulse SHALL occur, and late rd_valid_i SHALL be ignored.

Configuration
REQ-030 Macro OTP_ECC_READER_ERR_CNT_EN defined: adds output err_cnt_o [Aw:0], which counts failing words per sweep, saturates at Depth, is cleared on start and on reset, and holds after DONE.
REQ-031 Macro undefined: no port and no counter logic; all other behaviour identical.

Structure
REQ-032 Package otp_ecc_pkg SHALL hold part_info_t (packed struct, int x), the FSM state enum, DataWidth=64 and EccWidth=8.
REQ-033 Sub-module otp_ecc_byte_parity_chk SHALL be purely combinational: data[63:0] and ecc[7:0] in, syndrome[7:0] out. It is instantiated once.

Verification
REQ-034 Depth=4, words 0x1..0x4 with correct parity, gnt/valid immediate -> done_o at cycle 13 after start, err_o=0, digest_o=0x4.
REQ-035 Depth=4, word 2 ecc bit0 flipped -> err_o=1, err_addr_o=2; with the macro, err_cnt_o=1.
REQ-036 Words 1 and 3 corrupt -> err_addr_o=1; with the macro, err_cnt_o=2.
REQ-037 rd_gnt_i held low 5 cycles -> rd_req_o stays high with rd_addr_o stable; the sweep completes correctly.
REQ-038 rst_i pulsed during WAIT of word 1, then a late rd_valid_i -> outputs zero, state IDLE, no done_o.
REQ-039 Depth=1 (Info.x=1, Aw=1) with start_i held high -> one read at address 0, done_o, then an immediate restart.

Source files
------------

// File: rtl/otp_ecc_pkg.sv
// Shared types and constants for the OTP ECC register reader.
package otp_ecc_pkg;

  localparam int DataWidth = 64;
  localparam int EccWidth  = 8;

  typedef struct packed {
    int x;
  } part_info_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CHECK,
    DONE
  } state_e;

endpackage

// File: rtl/otp_ecc_byte_parity_chk.sv
// Per-byte even-parity syndrome: bit k is set when byte k disagrees with ecc bit k.
module otp_ecc_byte_parity_chk
  import otp_ecc_pkg::*;
(
  input  logic [DataWidth-1:0] data,
  input  logic [EccWidth-1:0]  ecc,
  output logic [EccWidth-1:0]  syndrome
);

  always_comb begin
    syndrome = '0;
    for (int unsigned k = 0; k < EccWidth; k++) begin
      syndrome[k] = (^data[8*k +: 8]) ^ ecc[k];
    end
  end

endmodule

// File: rtl/otp_ecc_reg_reader.sv
// Sweeps Depth words from ECC register storage, checks byte parity and XOR-digests the data.
// Optional per-sweep failing-word counter enabled by OTP_ECC_READER_ERR_CNT_EN.
module otp_ecc_reg_reader
  import otp_ecc_pkg::*;
#(
  parameter  int Depth = 1,
  localparam int Aw    = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 rd_req_o,
  output logic [Aw-1:0]        rd_addr_o,
  input  logic                 rd_gnt_i,
  input  logic                 rd_valid_i,
  input  logic [DataWidth-1:0] rd_data_i,
  input  logic [EccWidth-1:0]  rd_ecc_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [Aw-1:0]        err_addr_o,
`ifdef OTP_ECC_READER_ERR_CNT_EN
  output logic [Aw:0]          err_cnt_o,
`endif
  output logic [DataWidth-1:0] digest_o
);

  localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

  state_e               state_q, state_d;
  logic [Aw-1:0]        addr_q;
  logic [DataWidth-1:0] data_q;
  logic [EccWidth-1:0]  ecc_q;
  logic [DataWidth-1:0] digest_q;
  logic                 err_q;
  logic [Aw-1:0]        err_addr_q;
  logic [EccWidth-1:0]  syndrome;
  logic                 word_bad;

  otp_ecc_byte_parity_chk u_parity_chk (
    .data     (data_q),
    .ecc      (ecc_q),
    .syndrome (syndrome)
  );

  assign word_bad = |syndrome;

  always_comb begin
    state_d  = state_q;
    rd_req_o = 1'b0;
    busy_o   = 1'b1;
    done_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_d = REQ;
      end
      REQ: begin
        rd_req_o = 1'b1;
        if (rd_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (rd_valid_i) state_d = CHECK;
      end
      CHECK: begin
        state_d = (addr_q == LastAddr) ? DONE : REQ;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      ecc_q      <= '0;
      digest_q   <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            addr_q     <= '0;
            digest_q   <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
          end
        end
        WAIT: begin
          if (rd_valid_i) begin
            data_q <= rd_data_i;
            ecc_q  <= rd_ecc_i;
          end
        end
        CHECK: begin
          digest_q <= digest_q ^ data_q;
          if (word_bad && !err_q) begin
            err_q      <= 1'b1;
            err_addr_q <= addr_q;
          end
          if (addr_q != LastAddr) addr_q <= addr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef OTP_ECC_READER_ERR_CNT_EN
  localparam logic [Aw:0] CntMax = (Aw + 1)'(Depth);

  logic [Aw:0] err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      err_cnt_q <= '0;
    end else if (state_q == CHECK && word_bad && err_cnt_q < CntMax) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

  assign rd_addr_o  = addr_q;
  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;
  assign digest_o   = digest_q;

endmodule

// File: tb/tb_otp_ecc_reg_reader.sv
// Directed self-checking bench for otp_ecc_reg_reader (Depth=4 and Depth=1 instances).
module tb_otp_ecc_reg_reader;
  import otp_ecc_pkg::*;

  localparam part_info_t Info4 = '{x: 4};
  localparam part_info_t Info1 = '{x: 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, gnt, valid;
  logic [63:0] data;
  logic [7:0]  ecc;
  logic        req, busy, done, err;
  logic [1:0]  addr, err_addr;
  logic [63:0] digest;

  logic        s1_start, s1_gnt, s1_valid;
  logic [63:0] s1_data;
  logic [7:0]  s1_ecc;
  logic        s1_req, busy1, done1, err1;
  logic [0:0]  s1_addr, err_addr1;
  logic [63:0] digest1;

`ifdef OTP_ECC_READER_ERR_CNT_EN
  logic [2:0] err_cnt;
  logic [1:0] err_cnt1;
`endif

  otp_ecc_reg_reader #(.Depth(Info4.x)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .rd_req_o(req), .rd_addr_o(addr), .rd_gnt_i(gnt),
    .rd_valid_i(valid), .rd_data_i(data), .rd_ecc_i(ecc),
    .busy_o(busy), .done_o(done), .err_o(err), .err_addr_o(err_addr),
`ifdef OTP_ECC_READER_ERR_CNT_EN
    .err_cnt_o(err_cnt),
`endif
    .digest_o(digest)
  );

  otp_ecc_reg_reader #(.Depth(Info1.x)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(s1_start),
    .rd_req_o(s1_req), .rd_addr_o(s1_addr), .rd_gnt_i(s1_gnt),
    .rd_valid_i(s1_valid), .rd_data_i(s1_data), .rd_ecc_i(s1_ecc),
    .busy_o(busy1), .done_o(done1), .err_o(err1), .err_addr_o(err_addr1),
`ifdef OTP_ECC_READER_ERR_CNT_EN
    .err_cnt_o(err_cnt1),
`endif
    .digest_o(digest1)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] mem [4];
  logic [7:0]  emem[4];
  int done_at;
  int dn;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Storage responder: grants after `stall` REQ cycles, returns data the cycle after the grant.
  task automatic run_sweep(input int stall, output int done_cycle);
    bit         pend = 1'b0;
    bit         seen = 1'b0;
    logic [1:0] paddr = '0;
    logic [1:0] req_addr = '0;
    int         left = stall;
    done_cycle = -1;
    start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      valid = 1'b0;
      gnt   = 1'b0;
      if (pend) begin
        valid = 1'b1;
        data  = mem[paddr];
        ecc   = emem[paddr];
        pend  = 1'b0;
      end
      if (req) begin
        if (left > 0) begin
          if (!seen) begin
            req_addr = addr;
            seen     = 1'b1;
          end else begin
            chk("addr_stable_during_stall", 64'(addr), 64'(req_addr));
          end
          left--;
        end else begin
          gnt   = 1'b1;
          pend  = 1'b1;
          paddr = addr;
        end
      end
      if (done) begin
        done_cycle = c;
        break;
      end
    end
    if (done_cycle < 0) begin
      checks++;
      errors++;
      $error("FAIL done_timeout observed=no_done expected=done_pulse");
    end
    @(posedge clk); #1;
    valid = 1'b0;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; gnt = 1'b0; valid = 1'b0; data = '0; ecc = '0;
    s1_start = 1'b0; s1_gnt = 1'b0; s1_valid = 1'b0; s1_data = '0; s1_ecc = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_err_addr", 64'(err_addr), 64'd0);
    chk("rst_digest", digest, 64'd0);
    chk("rst_busy1", 64'(busy1), 64'd0);
`ifdef OTP_ECC_READER_ERR_CNT_EN
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif

    // Clean sweep
    mem[0] = 64'h1; mem[1] = 64'h2; mem[2] = 64'h3; mem[3] = 64'h4;
    emem[0] = 8'h01; emem[1] = 8'h01; emem[2] = 8'h00; emem[3] = 8'h01;
    run_sweep(0, done_at);
    chk("clean_done_cycle", 64'(done_at), 64'd13);
    chk("clean_err", 64'(err), 64'd0);
    chk("clean_digest", digest, 64'h4);
`ifdef OTP_ECC_READER_ERR_CNT_EN
    chk("clean_err_cnt", 64'(err_cnt), 64'd0);
`endif

    // Word 2 ecc bit0 flipped
    emem[2] = 8'h01;
    run_sweep(0, done_at);
    chk("w2_done_cycle", 64'(done_at), 64'd13);
    chk("w2_err", 64'(err), 64'd1);
    chk("w2_err_addr", 64'(err_addr), 64'd2);
    chk("w2_digest", digest, 64'h4);
`ifdef OTP_ECC_READER_ERR_CNT_EN
    chk("w2_err_cnt", 64'(err_cnt), 64'd1);
`endif

    // Words 1 and 3 corrupt, wider data patterns
    mem[0] = 64'h1;                   emem[0] = 8'h01;
    mem[1] = 64'h8000_0000_0000_00F0; emem[1] = 8'h00;
    mem[2] = 64'h0300;                emem[2] = 8'h00;
    mem[3] = 64'h4;                   emem[3] = 8'h03;
    run_sweep(0, done_at);
    chk("w13_err", 64'(err), 64'd1);
    chk("w13_err_addr", 64'(err_addr), 64'd1);
    chk("w13_digest", digest, 64'h8000_0000_0000_03F5);
`ifdef OTP_ECC_READER_ERR_CNT_EN
    chk("w13_err_cnt", 64'(err_cnt), 64'd2);
`endif

    // Grant stalled 5 cycles on the first word
    mem[0] = 64'h1; mem[1] = 64'h2; mem[2] = 64'h3; mem[3] = 64'h4;
    emem[0] = 8'h01; emem[1] = 8'h01; emem[2] = 8'h00; emem[3] = 8'h01;
    run_sweep(5, done_at);
    chk("stall_done_cycle", 64'(done_at), 64'd18);
    chk("stall_err", 64'(err), 64'd0);
    chk("stall_err_addr", 64'(err_addr), 64'd0);
    chk("stall_digest", digest, 64'h4);
`ifdef OTP_ECC_READER_ERR_CNT_EN
    chk("stall_err_cnt", 64'(err_cnt), 64'd0);
`endif

    // Reset during WAIT of word 1, then a late valid
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mr_req0", 64'(req), 64'd1);
    chk("mr_addr0", 64'(addr), 64'd0);
    gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0; valid = 1'b1; data = 64'h1; ecc = 8'h00;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    chk("mr_addr1", 64'(addr), 64'd1);
    chk("mr_err_pre", 64'(err), 64'd1);
    chk("mr_digest_pre", digest, 64'h1);
    gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
    chk("mr_busy_wait", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b1; data = 64'h2; ecc = 8'h01;
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_req", 64'(req), 64'd0);
    chk("mr_err", 64'(err), 64'd0);
    chk("mr_err_addr", 64'(err_addr), 64'd0);
    chk("mr_digest", digest, 64'd0);
    chk("mr_addr", 64'(addr), 64'd0);
    @(posedge clk); #1;
    valid = 1'b0;
    chk("mr_late_valid_busy", 64'(busy), 64'd0);
    dn = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("mr_no_done", 64'(dn), 64'd0);
    chk("mr_digest_hold", digest, 64'd0);

    // Depth=1 with start held high
    s1_start = 1'b1;
    @(posedge clk); #1;
    chk("d1_req", 64'(s1_req), 64'd1);
    chk("d1_addr", 64'(s1_addr), 64'd0);
    chk("d1_busy", 64'(busy1), 64'd1);
    s1_gnt = 1'b1;
    @(posedge clk); #1;
    s1_gnt = 1'b0; s1_valid = 1'b1; s1_data = 64'h5; s1_ecc = 8'h00;
    chk("d1_req_wait", 64'(s1_req), 64'd0);
    @(posedge clk); #1;
    s1_valid = 1'b0;
    chk("d1_no_done_check", 64'(done1), 64'd0);
    @(posedge clk); #1;
    chk("d1_done", 64'(done1), 64'd1);
    chk("d1_digest", digest1, 64'h5);
    chk("d1_err", 64'(err1), 64'd0);
    chk("d1_err_addr", 64'(err_addr1), 64'd0);
`ifdef OTP_ECC_READER_ERR_CNT_EN
    chk("d1_err_cnt", 64'(err_cnt1), 64'd0);
`endif
    @(posedge clk); #1;
    chk("d1_done_drop", 64'(done1), 64'd0);
    chk("d1_idle", 64'(busy1), 64'd0);
    chk("d1_digest_hold", digest1, 64'h5);
    @(posedge clk); #1;
    s1_start = 1'b0;
    chk("d1_restart_req", 64'(s1_req), 64'd1);
    chk("d1_restart_addr", 64'(s1_addr), 64'd0);
    chk("d1_restart_digest", digest1, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
